// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port byte-addressable memory between
// the pipeline MEM stage (port 0) and the loader/debug port (port 1).
// A granted command is registered onto the memory port for exactly one ACCESS
// cycle, and the response is returned one cycle later to the winning port only.
// Misaligned or malformed accesses are granted but never reach the memory.
module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    // port 0: pipeline MEM stage
    input  logic              i_p0_req,
    input  logic              i_p0_we,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [2:0]        i_p0_func3,
    input  logic [31:0]       i_p0_wdata,
    output logic              o_p0_gnt,
    output logic              o_p0_rvalid,
    output logic [31:0]       o_p0_rdata,
    output logic              o_p0_err,
    // port 1: loader / debug
    input  logic              i_p1_req,
    input  logic              i_p1_we,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [2:0]        i_p1_func3,
    input  logic [31:0]       i_p1_wdata,
    output logic              o_p1_gnt,
    output logic              o_p1_rvalid,
    output logic [31:0]       o_p1_rdata,
    output logic              o_p1_err,
    // memory port
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [2:0]        o_mem_func3,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    // Flags a command that must not touch memory: unknown width, store with an
    // unsigned-load width, or a halfword/word that is not naturally aligned.
    function automatic logic f_illegal(input logic we, input logic [1:0] alo,
                                       input logic [2:0] f3);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = alo[0];
            3'b010:  bad = |alo;
            3'b100:  bad = we;
            3'b101:  bad = we | alo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // ------------------------------------------------------------------
    // Per-port request bundles, gathered into arrays indexed by port.
    // ------------------------------------------------------------------
    logic [1:0]        w_req;
    logic [1:0]        w_we;
    logic [1:0]        w_illegal;
    logic [ADDR_W-1:0] w_addr  [2];
    logic [2:0]        w_func3 [2];
    logic [31:0]       w_wdata [2];

    assign w_req      = {i_p1_req, i_p0_req};
    assign w_we       = {i_p1_we, i_p0_we};
    assign w_addr[0]  = i_p0_addr;
    assign w_addr[1]  = i_p1_addr;
    assign w_func3[0] = i_p0_func3;
    assign w_func3[1] = i_p1_func3;
    assign w_wdata[0] = i_p0_wdata;
    assign w_wdata[1] = i_p1_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_decode
            assign w_illegal[gi] = f_illegal(w_we[gi], w_addr[gi][1:0], w_func3[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;
    logic              r_last;       // winner of the most recent grant
    logic              r_owner;      // port whose command is in flight
    logic              r_acc_err;    // in-flight command was rejected
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [2:0]        r_mem_func3;
    logic [31:0]       r_mem_wdata;
    logic [1:0]        r_rvalid;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_grant_any;
    logic              w_winner;

    // State register; an asynchronous reset aborts whatever is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and arbitration: grants only in IDLE, contest resolved by
    // round-robin (the port that did not win last) or fixed port-0 priority.
    always_comb begin
        w_state_next = r_state;
        w_grant_any  = 1'b0;
        w_winner     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_grant_any  = 1'b1;
                    w_state_next = S_ACCESS;
                    if (&w_req) begin
                        w_winner = (RR_EN != 0) ? ~r_last : 1'b0;
                    end else begin
                        w_winner = w_req[1];
                    end
                end
            end
            S_ACCESS: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command capture at grant, one-cycle memory strobe, response capture
    // during ACCESS; read data is zero for stores and rejected commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_acc_err   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_func3 <= '0;
            r_mem_wdata <= '0;
            r_rvalid    <= 2'b00;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rvalid    <= 2'b00;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (w_grant_any) begin
                r_mem_addr  <= w_addr[w_winner];
                r_mem_func3 <= w_func3[w_winner];
                r_mem_wdata <= w_wdata[w_winner];
                r_mem_read  <= ~w_we[w_winner] & ~w_illegal[w_winner];
                r_mem_write <= w_we[w_winner] & ~w_illegal[w_winner];
                r_acc_err   <= w_illegal[w_winner];
                r_owner     <= w_winner;
                r_last      <= w_winner;
            end
            if (r_state == S_ACCESS) begin
                r_rvalid[r_owner] <= 1'b1;
                r_rdata           <= r_mem_read ? i_mem_rdata : 32'h0;
                r_err             <= r_acc_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: response fields are only non-zero on the owning port.
    // ------------------------------------------------------------------
    logic [1:0]  w_gnt;
    logic [1:0]  w_err_out;
    logic [31:0] w_rdata_out [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_out
            assign w_gnt[gi]       = w_grant_any & (w_winner == 1'(gi));
            assign w_err_out[gi]   = r_rvalid[gi] & r_err;
            assign w_rdata_out[gi] = r_rvalid[gi] ? r_rdata : 32'h0;
        end
    endgenerate

    assign o_p0_gnt    = w_gnt[0];
    assign o_p1_gnt    = w_gnt[1];
    assign o_p0_rvalid = r_rvalid[0];
    assign o_p1_rvalid = r_rvalid[1];
    assign o_p0_rdata  = w_rdata_out[0];
    assign o_p1_rdata  = w_rdata_out[1];
    assign o_p0_err    = w_err_out[0];
    assign o_p1_err    = w_err_out[1];

    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_func3 = r_mem_func3;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural byte memory sits on the memory port,
// a scoreboard queue holds expected responses pushed at grant time, and a
// negedge monitor checks arbitration, memory strobes and responses.
module tb_dmem_arbiter;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_clear = 1'b1;
    always #5 clk = ~clk;

    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [2:0]    p0_func3 = '0;
    logic [31:0]   p0_wdata = '0;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [2:0]    p1_func3 = '0;
    logic [31:0]   p1_wdata = '0;

    logic          p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_func3;
    logic [31:0]   mem_wdata, mem_rdata;

    logic          fp_p0_gnt, fp_p0_rvalid, fp_p0_err, fp_p1_gnt, fp_p1_rvalid, fp_p1_err;
    logic [31:0]   fp_p0_rdata, fp_p1_rdata;
    logic          fp_mem_read, fp_mem_write;
    logic [AW-1:0] fp_mem_addr;
    logic [2:0]    fp_mem_func3;
    logic [31:0]   fp_mem_wdata;

    dmem_arbiter #(.ADDR_W(AW), .RR_EN(1)) u_dut (
        .clk(clk), .rst(rst),
        .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_func3(p0_func3),
        .i_p0_wdata(p0_wdata), .o_p0_gnt(p0_gnt), .o_p0_rvalid(p0_rvalid),
        .o_p0_rdata(p0_rdata), .o_p0_err(p0_err),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_func3(p1_func3),
        .i_p1_wdata(p1_wdata), .o_p1_gnt(p1_gnt), .o_p1_rvalid(p1_rvalid),
        .o_p1_rdata(p1_rdata), .o_p1_err(p1_err),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
        .o_mem_func3(mem_func3), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Fixed-priority instance sharing the request inputs; only its grants are checked.
    dmem_arbiter #(.ADDR_W(AW), .RR_EN(0)) u_fp (
        .clk(clk), .rst(rst),
        .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_func3(p0_func3),
        .i_p0_wdata(p0_wdata), .o_p0_gnt(fp_p0_gnt), .o_p0_rvalid(fp_p0_rvalid),
        .o_p0_rdata(fp_p0_rdata), .o_p0_err(fp_p0_err),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_func3(p1_func3),
        .i_p1_wdata(p1_wdata), .o_p1_gnt(fp_p1_gnt), .o_p1_rvalid(fp_p1_rvalid),
        .o_p1_rdata(fp_p1_rdata), .o_p1_err(fp_p1_err),
        .o_mem_read(fp_mem_read), .o_mem_write(fp_mem_write), .o_mem_addr(fp_mem_addr),
        .o_mem_func3(fp_mem_func3), .o_mem_wdata(fp_mem_wdata), .i_mem_rdata(32'h0)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural data memory on the memory port ----------------
    logic [7:0] env_mem [64];

    always_comb begin
        mem_rdata = 32'h0;
        case (mem_func3)
            3'b000: mem_rdata = {{24{env_mem[mem_addr][7]}}, env_mem[mem_addr]};
            3'b001: mem_rdata = {{16{env_mem[mem_addr + 6'd1][7]}}, env_mem[mem_addr + 6'd1],
                                 env_mem[mem_addr]};
            3'b010: mem_rdata = {env_mem[mem_addr + 6'd3], env_mem[mem_addr + 6'd2],
                                 env_mem[mem_addr + 6'd1], env_mem[mem_addr]};
            3'b100: mem_rdata = {24'h0, env_mem[mem_addr]};
            3'b101: mem_rdata = {16'h0, env_mem[mem_addr + 6'd1], env_mem[mem_addr]};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= 8'(i * 37 + 11);
        end else if (mem_write) begin
            env_mem[mem_addr] <= mem_wdata[7:0];
            if (mem_func3[1:0] != 2'b00) env_mem[mem_addr + 6'd1] <= mem_wdata[15:8];
            if (mem_func3[1:0] == 2'b10) begin
                env_mem[mem_addr + 6'd2] <= mem_wdata[23:16];
                env_mem[mem_addr + 6'd3] <= mem_wdata[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [64];

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_illegal(input logic we, input logic [AW-1:0] a, input logic [2:0] f3);
        if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
        if (we && f3 >= 3'd4) return 1'b1;
        return (int'(a) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [AW-1:0] a, input logic [2:0] f3);
        longint v;
        int n;
        n = nbytes(f3);
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_mem[(int'(a) + k) % 64]) * (longint'(1) << (8 * k));
        if (f3 < 3'd4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [AW-1:0] a, input logic [2:0] f3, input logic [31:0] wd);
        for (int k = 0; k < nbytes(f3); k++) ref_mem[(int'(a) + k) % 64] = wd[8 * k +: 8];
    endtask

    typedef struct {
        int            port;
        logic          rd;
        logic          wr;
        logic [31:0]   rdata;
        logic          err;
        int            acc;
        logic [AW-1:0] addr;
        logic [2:0]    f3;
        logic [31:0]   wdata;
    } exp_t;

    exp_t  q[$];
    int    cyc = 0;
    bit    busy = 1'b0;
    bit    last = 1'b1;
    exp_t  m_e;
    logic  m_w;
    logic  m_we;
    logic [AW-1:0] m_a;
    logic [2:0]    m_f;
    logic [31:0]   m_rd;
    bit    m_ill;

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (mem_clear) for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 11);
        if (rst) begin
            q.delete();
            busy = 1'b0;
            last = 1'b1;
        end else begin
            cyc++;
            // memory strobes
            if (q.size() > 0 && q[0].acc == cyc) begin
                check("mem_read", mem_read, q[0].rd);
                check("mem_write", mem_write, q[0].wr);
                if (q[0].rd || q[0].wr) begin
                    check("mem_addr", mem_addr, q[0].addr);
                    check("mem_func3", mem_func3, q[0].f3);
                end
                if (q[0].wr) begin
                    check("mem_wdata", mem_wdata, q[0].wdata);
                    ref_store(q[0].addr, q[0].f3, q[0].wdata);
                end
            end else begin
                check("idle_mem_read", mem_read, 0);
                check("idle_mem_write", mem_write, 0);
            end
            // responses
            if (p0_rvalid || p1_rvalid) begin
                if (p0_rvalid && p1_rvalid) check("dual_rvalid", 1, 0);
                if (q.size() == 0) begin
                    check("spurious_rvalid", 1, 0);
                end else begin
                    m_e = q.pop_front();
                    check("rsp_port", p1_rvalid, m_e.port);
                    check("rsp_cycle", cyc, m_e.acc + 1);
                    check("rsp_rdata", p1_rvalid ? p1_rdata : p0_rdata, m_e.rdata);
                    check("rsp_err", p1_rvalid ? p1_err : p0_err, m_e.err);
                    $display("rsp p%0d we=%0d addr=%0d f3=%0d rdata=%08h err=%0d",
                             m_e.port, m_e.wr, m_e.addr, m_e.f3,
                             p1_rvalid ? p1_rdata : p0_rdata, p1_rvalid ? p1_err : p0_err);
                end
            end else if (q.size() > 0 && cyc > q[0].acc) begin
                check("missing_rvalid", 0, 1);
                void'(q.pop_front());
            end
            // arbitration
            if (p0_gnt && p1_gnt) check("dual_gnt", 1, 0);
            if (busy) begin
                check("gnt_in_access", {p1_gnt, p0_gnt}, 0);
            end else if (p0_req || p1_req) begin
                m_w = (p0_req && p1_req) ? !last : p1_req;
                check("gnt_p0", p0_gnt, !m_w);
                check("gnt_p1", p1_gnt, m_w);
            end else begin
                check("gnt_noreq", {p1_gnt, p0_gnt}, 0);
            end
            busy = 1'b0;
            if (p0_gnt ^ p1_gnt) begin
                m_w   = p1_gnt;
                m_we  = m_w ? p1_we : p0_we;
                m_a   = m_w ? p1_addr : p0_addr;
                m_f   = m_w ? p1_func3 : p0_func3;
                m_ill = ref_illegal(m_we, m_a, m_f);
                m_rd  = (!m_we && !m_ill) ? ref_load(m_a, m_f) : 32'h0;
                q.push_back('{port: int'(m_w), rd: !m_we && !m_ill, wr: m_we && !m_ill,
                              rdata: m_rd, err: m_ill, acc: cyc + 1, addr: m_a, f3: m_f,
                              wdata: m_w ? p1_wdata : p0_wdata});
                last = m_w;
                busy = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [2:0] f3, input logic [31:0] wd);
        int n;
        @(posedge clk); #1;
        if (p == 0) begin
            p0_we = we; p0_addr = a; p0_func3 = f3; p0_wdata = wd; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = a; p1_func3 = f3; p1_wdata = wd; p1_req = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((p == 0) ? p0_gnt : p1_gnt) && n < 50);
        if (n >= 50) check("gnt_timeout", 0, 1);
        @(posedge clk); #1;
        if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    task automatic wait_rsp(input int p, output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((p == 0) ? p0_rvalid : p1_rvalid) && n < 6);
        if (n >= 6) check("rsp_timeout", 0, 1);
        rd = (p == 0) ? p0_rdata : p1_rdata;
        er = (p == 0) ? p0_err : p1_err;
    endtask

    task automatic rand_driver(input int p, input int nops);
        logic [AW-1:0] a;
        for (int i = 0; i < nops; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a = AW'($urandom);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            issue(p, 1'($urandom), a, 3'($urandom), $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        #1 rst = 1'b1;
        #2;
        check("rst_p0_gnt", p0_gnt, 0);
        check("rst_p1_gnt", p1_gnt, 0);
        check("rst_rvalid", {p1_rvalid, p0_rvalid}, 0);
        check("rst_rdata", p0_rdata | p1_rdata, 0);
        check("rst_err", {p1_err, p0_err}, 0);
        check("rst_mem_rw", {mem_write, mem_read}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_func3", mem_func3, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        repeat (2) @(posedge clk);
        #1 mem_clear = 1'b0;
        rst = 1'b0;

        // single load: bytes {20,9,4,0} at 0..3 written by the loader port first
        issue(1, 1'b1, 6'd0, 3'b010, 32'h0004_0914);
        wait_rsp(1, rd, er);
        check("sw0_rdata", rd, 0);
        check("sw0_err", er, 0);
        @(posedge clk); #1;
        p0_we = 1'b0; p0_addr = 6'd0; p0_func3 = 3'b010; p0_req = 1'b1;
        @(negedge clk);
        check("lw0_gnt_c0", p0_gnt, 1);
        @(posedge clk); #1 p0_req = 1'b0;
        @(negedge clk);
        check("lw0_mem_read_c1", mem_read, 1);
        @(negedge clk);
        check("lw0_rvalid_c2", p0_rvalid, 1);
        check("lw0_rdata_c2", p0_rdata, 32'h0004_0914);
        check("lw0_err_c2", p0_err, 0);

        // store byte then load unsigned / signed
        issue(1, 1'b1, 6'd5, 3'b000, 32'h1234_56AB);
        wait_rsp(1, rd, er);
        issue(0, 1'b0, 6'd5, 3'b100, 32'h0);
        wait_rsp(0, rd, er);
        check("lbu5", rd, 32'h0000_00AB);
        issue(0, 1'b0, 6'd5, 3'b000, 32'h0);
        wait_rsp(0, rd, er);
        check("lb5", rd, 32'hFFFF_FFAB);

        // misaligned word load and halfword store
        issue(0, 1'b0, 6'd2, 3'b010, 32'h0);
        @(negedge clk);
        check("mis_lw_mem_read", mem_read, 0);
        check("mis_lw_mem_write", mem_write, 0);
        @(negedge clk);
        check("mis_lw_rvalid", p0_rvalid, 1);
        check("mis_lw_err", p0_err, 1);
        check("mis_lw_rdata", p0_rdata, 0);
        issue(0, 1'b1, 6'd3, 3'b001, 32'h0000_FFFF);
        wait_rsp(0, rd, er);
        check("mis_sh_err", er, 1);
        check("mis_sh_byte3", env_mem[3], ref_mem[3]);
        check("mis_sh_byte4", env_mem[4], ref_mem[4]);

        // contention straight out of reset: RR alternates, fixed priority keeps port 0
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        p0_we = 1'b0; p0_addr = 6'd0; p0_func3 = 3'b010;
        p1_we = 1'b0; p1_addr = 6'd4; p1_func3 = 3'b010;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_p0_gnt", p0_gnt, (k % 4) == 0);
            check("rr_p1_gnt", p1_gnt, (k % 4) == 2);
            check("fp_p0_gnt", fp_p0_gnt, (k % 2) == 0);
            check("fp_p1_gnt", fp_p1_gnt, 0);
        end
        @(posedge clk); #1 p0_req = 1'b0; p1_req = 1'b0;
        repeat (3) @(negedge clk);

        // reset during the ACCESS cycle of a store aborts it
        issue(0, 1'b1, 6'd8, 3'b010, 32'hDEAD_BEEF);
        #1 rst = 1'b1;
        #1;
        check("rst_abort_mem_write", mem_write, 0);
        check("rst_abort_mem_addr", mem_addr, 0);
        check("rst_abort_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_abort_no_rvalid", p0_rvalid, 0);
        end
        for (int k = 8; k < 12; k++) check("rst_abort_mem", env_mem[k], ref_mem[k]);
        @(posedge clk); #1;
        p0_we = 1'b0; p0_addr = 6'd8; p0_func3 = 3'b010;
        p1_we = 1'b0; p1_addr = 6'd12; p1_func3 = 3'b010;
        p0_req = 1'b1; p1_req = 1'b1;
        @(negedge clk);
        check("post_rst_p0_wins", p0_gnt, 1);
        check("post_rst_p1_waits", p1_gnt, 0);
        @(posedge clk); #1 p0_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 p1_req = 1'b0;
        repeat (4) @(negedge clk);

        // random traffic from both ports
        fork
            rand_driver(0, 150);
            rand_driver(1, 150);
        join
        repeat (5) @(negedge clk);
        check("drain_queue", q.size(), 0);
        for (int i = 0; i < 64; i++) check("final_mem", env_mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
